simpleuart_rx: RTL and testbench
================================

// Module: simpleuart_rx
// PURPOSE
//  Receive side of the system UART: 8N1 serial receiver with a byte FIFO, read by picorv32
//  over the native memory bus. Pairs with the simpleuart transmitter; same divider semantics.
//  Top decode: data reg at 32'h1000_0004, status 32'h1000_0008, divider 32'h1000_000C.
// PARAMETERS
//  DEFAULT_DIV  234  reset value of cfg_divider, clk cycles per bit (27 MHz / 234 ~ 115200)
//  FIFO_DEPTH   16   RX FIFO entries; power of two, 2..256
// PORTS
//  clk          in   1   system clock
//  resetn       in   1   asynchronous reset, active-low
//  ser_rx       in   1   serial input, idle high, asynchronous to clk
//  reg_div_we   in   4   byte write strobes for cfg_divider
//  reg_div_di   in   32  divider write data
//  reg_div_do   out  32  current cfg_divider
//  reg_dat_re   in   1   one-cycle read strobe for data reg; pops FIFO
//  reg_dat_do   out  32  {24'h0,head byte} if FIFO non-empty, else 32'hFFFF_FFFF
//  reg_sts_re   in   1   one-cycle read strobe for status reg; clears sticky flags
//  reg_sts_do   out  32  {16'h0, count[7:0], 5'h0, ferr, ovr, !empty}
//  rx_irq       out  1   level: FIFO non-empty
// BEHAVIOUR
//  Reset: cfg_divider=DEFAULT_DIV; FIFO empty; ovr=ferr=0; rx_irq=0; reg_dat_do=32'hFFFF_FFFF;
//   synchroniser FFs=1; FSM=IDLE. All outputs valid immediately after reset deassertion.
//  ser_rx passes a 2-FF synchroniser (rx_s); all timing below is relative to rx_s.
//  Divider: D = max(cfg_divider,4); D latched at start detection, used for whole frame;
//   writes mid-frame affect the next frame only. Byte-lane writes per reg_div_we bit.
//  FSM:
//   IDLE   : rx_s==0 at cycle t -> START, bit counter loaded with D/2 (floor).
//   START  : at t+D/2 sample; rx_s==0 -> DATA; rx_s==1 -> IDLE (glitch, nothing recorded).
//   DATA   : bit i (0..7, LSB first) sampled at t+D/2+(i+1)*D into shift register.
//   STOP   : sampled at t+D/2+9*D. 1 -> push byte, -> IDLE. 0 -> set ferr, drop byte, -> BREAK.
//   BREAK  : wait for rx_s==1, then IDLE (long breaks produce exactly one ferr, no bytes).
//  Push: byte visible at reg_dat_do and rx_irq high the cycle after the stop sample.
//  Full: push while full and no pop -> byte dropped, ovr set; FIFO contents unchanged.
//  Simultaneous push+pop: both happen, count unchanged; holds when full (no ovr) and when
//   count==1. Pop when empty: ignored, no state change, reg_dat_do stays 32'hFFFF_FFFF.
//  reg_dat_do is combinational from FIFO head; pop takes effect at the strobe's clock edge.
//  Sticky flags: reg_sts_re clears ovr/ferr; a set event in the same cycle wins (flag stays 1).
//  reg_sts_do count = FIFO occupancy, saturates at FIFO_DEPTH (256 reports as 8'hFF).
//  Reset mid-frame: frame abandoned, all state to reset values; no partial byte pushed.
// STRUCTURE
//  Package uart_pkg: FSM state enum (IDLE,START,DATA,STOP,BREAK), status bit indices,
//   DEFAULT_DIV constant shared with simpleuart, clog2 helper for FIFO pointer width.
//  Sub-module uart_rx_fifo: sync FIFO, width 8, depth FIFO_DEPTH, push/pop/full/empty/count,
//   pointers one bit wider than address; same clk/resetn.
//  Top of block: synchroniser, divider reg, bit-timing counter, FSM, shift reg, flags.
// TESTING (bench overrides DEFAULT_DIV=16 unless stated)
//  1 Send 8'hA5 8N1 at 16 clk/bit -> reg_dat_do=32'h0000_00A5 one cycle after stop sample,
//    rx_irq=1; pulse reg_dat_re -> reg_dat_do=32'hFFFF_FFFF, rx_irq=0.
//  2 Low glitch of 5 clk on idle line -> no push, ferr=0, FSM back in IDLE by cycle t+8.
//  3 Send 17 bytes 8'h00..8'h10 with no reads (DEPTH=16) -> count=16, ovr=1, reads return
//    8'h00..8'h0F then 32'hFFFF_FFFF; reg_sts_re then reg_sts_do=32'h0.
//  4 Frame 8'h55 with stop bit 0, then line held low 100 bit-times, then 8'h3C -> ferr=1,
//    only 8'h3C in FIFO.
//  5 FIFO full; pop in same cycle as stop sample of 8'h77 -> count stays 16, ovr=0, 8'h77 last.
//  6 Write divider to 32 during frame of 8'hC3 at 16 -> 8'hC3 correct; next frame at 32 clk/bit
//    of 8'h81 correct; assert resetn=0 mid third frame -> FIFO empty, reg_div_do=16.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, status register bit positions,
// the default baud divider used by both UART directions, and a log2 helper.
package uart_pkg;

  // 27 MHz / 234 gives roughly 115200 baud.
  localparam logic [31:0] UART_DEFAULT_DIV = 32'd234;

  // Smallest divider the receiver will actually use.
  localparam logic [31:0] UART_MIN_DIV = 32'd4;

  // Bit positions inside the status register.
  localparam int STS_VALID = 0;
  localparam int STS_OVR   = 1;
  localparam int STS_FERR  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Ceiling log2, used to size FIFO address pointers.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/simpleuart_rx_if.sv
// CPU-side register bus of the UART receiver: divider, data and status ports.
interface simpleuart_rx_if;

  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di;
  logic [31:0] reg_div_do;
  logic        reg_dat_re;
  logic [31:0] reg_dat_do;
  logic        reg_sts_re;
  logic [31:0] reg_sts_do;

  modport master (
    output reg_div_we, reg_div_di, reg_dat_re, reg_sts_re,
    input  reg_div_do, reg_dat_do, reg_sts_do
  );

  modport slave (
    input  reg_div_we, reg_div_di, reg_dat_re, reg_sts_re,
    output reg_div_do, reg_dat_do, reg_sts_do
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO for received characters. Pointers carry one extra
// wrap bit so full and empty can be told apart without a separate counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push_i,
  input  logic [7:0]  pushData_i,
  input  logic        pop_i,
  output logic [7:0]  headData_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wrPtr_q, wrPtr_d;
  logic [AW:0] rdPtr_q, rdPtr_d;
  logic        wrEn;
  logic        rdEn;

  assign empty_o    = (wrPtr_q == rdPtr_q);
  assign full_o     = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                      (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign count_o    = wrPtr_q - rdPtr_q;
  assign headData_o = mem[rdPtr_q[AW-1:0]];

  // A push into a full FIFO still lands if the head is leaving in the same cycle;
  // a pop from an empty FIFO is simply ignored.
  always_comb begin
    wrEn    = push_i && (!full_o || pop_i);
    rdEn    = pop_i && !empty_o;
    wrPtr_d = wrEn ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = rdEn ? rdPtr_q + 1'b1 : rdPtr_q;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr_q[AW-1:0]] <= pushData_i;
  end

endmodule

// File: rtl/simpleuart_rx.sv
// 8N1 UART receiver with a byte FIFO and a small register interface for the CPU.
// Bit timing is derived from a programmable divider that is latched at each start bit.
module simpleuart_rx
  import uart_pkg::*;
#(
  parameter logic [31:0] DEFAULT_DIV = UART_DEFAULT_DIV,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           ser_rx,
  simpleuart_rx_if.slave bus,
  output logic           rx_irq
);

  localparam int CW = clog2(FIFO_DEPTH) + 1;

  logic        rxMeta_q;
  logic        rxSync_q;
  logic [31:0] cfgDiv_q, cfgDiv_d;
  logic [31:0] bitDiv_q, bitDiv_d;
  logic [31:0] tick_q, tick_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic [7:0]  shift_q, shift_d;
  rx_state_t   state_q, state_d;
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;

  logic [31:0] effDiv;
  logic        sampleNow;
  logic        push;
  logic        ferrSet;
  logic        ovrSet;
  logic [7:0]  headData;
  logic        fifoFull;
  logic        fifoEmpty;
  logic [CW-1:0] fifoCount;
  logic [8:0]  count9;
  logic [7:0]  countSat;

  assign effDiv    = (cfgDiv_q < UART_MIN_DIV) ? UART_MIN_DIV : cfgDiv_q;
  assign sampleNow = (tick_q == 32'd1);

  // Two-flop synchroniser for the asynchronous serial line, idling high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= ser_rx;
      rxSync_q <= rxMeta_q;
    end
  end

  // Byte-lane writes to the divider register.
  always_comb begin
    cfgDiv_d = cfgDiv_q;
    for (int lane = 0; lane < 4; lane++) begin
      if (bus.reg_div_we[lane]) cfgDiv_d[lane*8 +: 8] = bus.reg_div_di[lane*8 +: 8];
    end
  end

  // Frame FSM: half-bit wait to the start-bit centre, then one full bit per sample.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    bitDiv_d = bitDiv_q;
    push     = 1'b0;
    ferrSet  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxSync_q) begin
          state_d  = START;
          bitDiv_d = effDiv;
          tick_d   = effDiv >> 1;
        end
      end
      START: begin
        if (sampleNow) begin
          if (!rxSync_q) begin
            state_d  = DATA;
            tick_d   = bitDiv_q;
            bitIdx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tick_d = tick_q - 32'd1;
        end
      end
      DATA: begin
        if (sampleNow) begin
          shift_d = {rxSync_q, shift_q[7:1]};
          tick_d  = bitDiv_q;
          if (bitIdx_q == 3'd7) state_d = STOP;
          else bitIdx_d = bitIdx_q + 3'd1;
        end else begin
          tick_d = tick_q - 32'd1;
        end
      end
      STOP: begin
        if (sampleNow) begin
          if (rxSync_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferrSet = 1'b1;
            state_d = BREAK;
          end
        end else begin
          tick_d = tick_q - 32'd1;
        end
      end
      BREAK: begin
        if (rxSync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky error flags: a new error in the same cycle as a status read wins.
  always_comb begin
    ovrSet = push && fifoFull && !bus.reg_dat_re;
    ovr_d  = ovrSet ? 1'b1 : (bus.reg_sts_re ? 1'b0 : ovr_q);
    ferr_d = ferrSet ? 1'b1 : (bus.reg_sts_re ? 1'b0 : ferr_q);
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfgDiv_q <= DEFAULT_DIV;
      bitDiv_q <= DEFAULT_DIV;
      tick_q   <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      state_q  <= IDLE;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      cfgDiv_q <= cfgDiv_d;
      bitDiv_q <= bitDiv_d;
      tick_q   <= tick_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      state_q  <= state_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (push),
    .pushData_i (shift_q),
    .pop_i      (bus.reg_dat_re),
    .headData_o (headData),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount)
  );

  // Register read-back; occupancy saturates so a 256-deep FIFO still fits 8 bits.
  always_comb begin
    count9                    = 9'(fifoCount);
    countSat                  = count9[8] ? 8'hFF : count9[7:0];
    bus.reg_div_do            = cfgDiv_q;
    bus.reg_dat_do            = fifoEmpty ? 32'hFFFF_FFFF : {24'h0, headData};
    bus.reg_sts_do            = {16'h0, countSat, 8'h0};
    bus.reg_sts_do[STS_VALID] = !fifoEmpty;
    bus.reg_sts_do[STS_OVR]   = ovr_q;
    bus.reg_sts_do[STS_FERR]  = ferr_q;
    rx_irq                    = !fifoEmpty;
  end

endmodule

// File: tb/tb_simpleuart_rx.sv
// Directed bench for the UART receiver: a vector table of single frames plus
// hand-written sequences for overflow, break, pop/push collision and divider changes.
module tb_simpleuart_rx;

  logic clk;
  logic resetn;
  logic ser_rx;
  logic rx_irq;

  int compared;
  int mismatched;
  int cycleCnt;
  int startCycle;
  int riseCycle;
  logic irqPrev;

  simpleuart_rx_if bus ();

  simpleuart_rx #(
    .DEFAULT_DIV (32'd16),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .ser_rx (ser_rx),
    .bus    (bus),
    .rx_irq (rx_irq)
  );

  typedef struct {
    logic [7:0]  data;
    logic        stopBit;
    logic [31:0] expDat;
    logic [31:0] expSts;
  } vec_t;

  vec_t vecs [5];

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time events relative to a frame start.
  always @(posedge clk) cycleCnt++;

  // Records the cycle in which rx_irq first rises after being re-armed.
  always @(posedge clk) begin
    #1;
    if (rx_irq && !irqPrev && riseCycle < 0) riseCycle = cycleCnt;
    irqPrev = rx_irq;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] data, input logic stopBit, input int bpc, input int extraLow);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      ser_rx = frame[b];
      repeat (bpc) @(negedge clk);
    end
    if (!stopBit) repeat (extraLow) @(negedge clk);
    ser_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic readData(output logic [31:0] v);
    v = bus.reg_dat_do;
    bus.reg_dat_re = 1'b1;
    @(negedge clk);
    bus.reg_dat_re = 1'b0;
  endtask

  task automatic readStatus(output logic [31:0] v);
    v = bus.reg_sts_do;
    bus.reg_sts_re = 1'b1;
    @(negedge clk);
    bus.reg_sts_re = 1'b0;
  endtask

  task automatic writeDiv(input logic [3:0] we, input logic [31:0] di);
    bus.reg_div_we = we;
    bus.reg_div_di = di;
    @(negedge clk);
    bus.reg_div_we = 4'h0;
    bus.reg_div_di = 32'h0;
  endtask

  task automatic applyStimulus();
    logic [31:0] v;
    for (int i = 0; i < 5; i++) begin
      sendByte(vecs[i].data, vecs[i].stopBit, 16, 0);
      checkOutput($sformatf("vec%0d dat", i), bus.reg_dat_do, vecs[i].expDat);
      readStatus(v);
      checkOutput($sformatf("vec%0d sts", i), v, vecs[i].expSts);
      readData(v);
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] popVal;

    compared   = 0;
    mismatched = 0;
    cycleCnt   = 0;
    riseCycle  = -1;
    irqPrev    = 1'b0;
    resetn     = 1'b0;
    ser_rx     = 1'b1;
    bus.reg_div_we = 4'h0;
    bus.reg_div_di = 32'h0;
    bus.reg_dat_re = 1'b0;
    bus.reg_sts_re = 1'b0;

    vecs[0] = '{8'h3A, 1'b1, 32'h0000_003A, 32'h0000_0101};
    vecs[1] = '{8'h00, 1'b1, 32'h0000_0000, 32'h0000_0101};
    vecs[2] = '{8'hFF, 1'b1, 32'h0000_00FF, 32'h0000_0101};
    vecs[3] = '{8'h5A, 1'b0, 32'hFFFF_FFFF, 32'h0000_0004};
    vecs[4] = '{8'h80, 1'b1, 32'h0000_0080, 32'h0000_0101};

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Reset state.
    checkOutput("reset div", bus.reg_div_do, 32'd16);
    checkOutput("reset dat", bus.reg_dat_do, 32'hFFFF_FFFF);
    checkOutput("reset sts", bus.reg_sts_do, 32'h0);
    checkOutput("reset irq", {31'h0, rx_irq}, 32'h0);

    // Single frame, exact push latency, then pop.
    riseCycle  = -1;
    startCycle = cycleCnt;
    sendByte(8'hA5, 1'b1, 16, 0);
    checkOutput("A5 irq latency", riseCycle - startCycle, 32'd155);
    checkOutput("A5 dat", bus.reg_dat_do, 32'h0000_00A5);
    checkOutput("A5 irq", {31'h0, rx_irq}, 32'h1);
    readData(v);
    checkOutput("A5 popped", v, 32'h0000_00A5);
    checkOutput("A5 dat after pop", bus.reg_dat_do, 32'hFFFF_FFFF);
    checkOutput("A5 irq after pop", {31'h0, rx_irq}, 32'h0);

    // Start-bit glitch shorter than half a bit.
    ser_rx = 1'b0;
    repeat (5) @(negedge clk);
    ser_rx = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("glitch sts", bus.reg_sts_do, 32'h0);
    checkOutput("glitch irq", {31'h0, rx_irq}, 32'h0);

    applyStimulus();

    // Overflow with 17 frames into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) sendByte(8'(i), 1'b1, 16, 0);
    checkOutput("ovf sts", bus.reg_sts_do, 32'h0000_1003);
    for (int i = 0; i < 16; i++) begin
      readData(v);
      checkOutput($sformatf("ovf read %0d", i), v, 32'(i));
    end
    readData(v);
    checkOutput("ovf read empty", v, 32'hFFFF_FFFF);
    readStatus(v);
    checkOutput("ovf sts before clear", v, 32'h0000_0002);
    checkOutput("ovf sts cleared", bus.reg_sts_do, 32'h0);

    // Framing error followed by a long break, then a good frame.
    sendByte(8'h55, 1'b0, 16, 1600);
    repeat (20) @(negedge clk);
    sendByte(8'h3C, 1'b1, 16, 0);
    readStatus(v);
    checkOutput("break sts", v, 32'h0000_0105);
    readData(v);
    checkOutput("break dat", v, 32'h0000_003C);
    checkOutput("break empty", bus.reg_dat_do, 32'hFFFF_FFFF);

    // Full FIFO with a pop landing on the stop-sample cycle.
    for (int i = 0; i < 16; i++) sendByte(8'h20 + 8'(i), 1'b1, 16, 0);
    checkOutput("full sts", bus.reg_sts_do, 32'h0000_1001);
    popVal = 32'h0;
    fork
      sendByte(8'h77, 1'b1, 16, 0);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        popVal = bus.reg_dat_do;
        bus.reg_dat_re = 1'b1;
        @(negedge clk);
        bus.reg_dat_re = 1'b0;
      end
    join
    checkOutput("collide popped", popVal, 32'h0000_0020);
    checkOutput("collide sts", bus.reg_sts_do, 32'h0000_1001);
    for (int i = 0; i < 16; i++) begin
      readData(v);
      checkOutput($sformatf("collide read %0d", i), v, (i == 15) ? 32'h77 : 32'h21 + 32'(i));
    end
    checkOutput("collide empty", bus.reg_dat_do, 32'hFFFF_FFFF);

    // Divider change mid-frame affects only the following frame.
    fork
      sendByte(8'hC3, 1'b1, 16, 0);
      begin
        repeat (60) @(negedge clk);
        writeDiv(4'hF, 32'd32);
      end
    join
    checkOutput("div32 readback", bus.reg_div_do, 32'd32);
    readData(v);
    checkOutput("C3 at old div", v, 32'h0000_00C3);
    sendByte(8'h81, 1'b1, 32, 0);
    readData(v);
    checkOutput("81 at div32", v, 32'h0000_0081);

    // Reset in the middle of a frame.
    ser_rx = 1'b0;
    repeat (32) @(negedge clk);
    ser_rx = 1'b1;
    repeat (32) @(negedge clk);
    ser_rx = 1'b0;
    repeat (32) @(negedge clk);
    resetn = 1'b0;
    ser_rx = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midreset div", bus.reg_div_do, 32'd16);
    checkOutput("midreset dat", bus.reg_dat_do, 32'hFFFF_FFFF);
    checkOutput("midreset sts", bus.reg_sts_do, 32'h0);
    resetn = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("postreset sts", bus.reg_sts_do, 32'h0);

    // Byte-lane write and a divider below the minimum.
    writeDiv(4'b0010, 32'h1234_5678);
    checkOutput("lane1 write", bus.reg_div_do, 32'h0000_5610);
    writeDiv(4'hF, 32'd2);
    checkOutput("div2 readback", bus.reg_div_do, 32'd2);
    sendByte(8'h96, 1'b1, 4, 0);
    readData(v);
    checkOutput("96 at min div", v, 32'h0000_0096);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
